multicycle_control_fsm: RTL

//  Multi-cycle sequencer for the CPU datapath (PC, IR, regfile, ALU, data memory).

---
 rtl/multicycle_control_fsm.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle IF/ID/EXE/MEM/WB sequencer driving the CPU datapath strobes,
// with a data-memory ready handshake, memory timeout and a retired-instruction counter.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             sign,
    input  logic             MemReady,
    output logic             PCWre,
    output logic [1:0]       PCSrc,
    output logic             IRWre,
    output logic             InsMemRW,
    output logic             ExtSel,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic             mRD,
    output logic             mWR,
    output logic             RegWre,
    output logic             RegDst,
    output logic             DBDataSrc,
    output logic [3:0]       State,
    output logic             Halted,
    output logic             MemErr,
    output logic [CNT_W-1:0] InstrCount
);
    typedef enum logic [3:0] {
        S_IF, S_ID, S_EXE_AL, S_EXE_BR, S_EXE_LS, S_MEM, S_WB_AL, S_WB_LD, S_HALT
    } state_t;
    state_t state, nxt;
    logic [5:0] op_q, op;
    logic [7:0] tmo;
    logic is_al, is_br, is_ls, is_lw, is_j, is_halt, is_sll, is_imm, is_zx, taken;
    logic [2:0] alu_op;
    // ID decodes the live opcode; later states use the copy latched in ID
    always_comb begin
        op = state == S_ID ? opcode : op_q;
        is_al = op inside {6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                           6'b010010, 6'b010011, 6'b011000, 6'b011100};
        is_br = op inside {6'b110000, 6'b110001, 6'b110010};
        is_ls = op inside {6'b100110, 6'b100111};
        is_lw = op == 6'b100111;
        is_j = op == 6'b111000;
        is_halt = op == 6'b111111;
        is_sll = op == 6'b011000;
        is_imm = op inside {6'b000010, 6'b010000, 6'b010010, 6'b011100};
        is_zx = op inside {6'b010000, 6'b010010};
        alu_op = op == 6'b000001 ? 3'b001 :
                 op == 6'b011000 ? 3'b010 :
                 op inside {6'b010000, 6'b010001} ? 3'b100 :
                 op inside {6'b010010, 6'b010011} ? 3'b011 :
                 op == 6'b011100 ? 3'b110 : 3'b000;
        taken = (op == 6'b110000 && zero) || (op == 6'b110001 && !zero) || (op == 6'b110010 && sign);
    end
    always_comb begin
        nxt = state;
        PCWre = 1'b0;
        PCSrc = 2'b00;
        IRWre = 1'b0;
        InsMemRW = 1'b0;
        ExtSel = 1'b0;
        ALUSrcA = 1'b0;
        ALUSrcB = 1'b0;
        ALUOp = 3'b000;
        mRD = 1'b0;
        mWR = 1'b0;
        RegWre = 1'b0;
        RegDst = 1'b0;
        DBDataSrc = 1'b0;
        State = RST ? 4'd0 : state;
        Halted = !RST && state == S_HALT;
        if (!RST) begin
            case (state)
                S_IF: begin
                    IRWre = 1'b1;
                    nxt = S_ID;
                end
                S_ID: begin
                    nxt = is_halt ? S_HALT : is_al ? S_EXE_AL : is_br ? S_EXE_BR : is_ls ? S_EXE_LS : S_IF;
                    PCWre = !(is_halt || is_al || is_br || is_ls);
                    PCSrc = is_j ? 2'b10 : 2'b00;
                end
                S_EXE_AL, S_WB_AL: begin
                    ALUOp = alu_op;
                    ALUSrcA = is_sll;
                    ALUSrcB = is_imm;
                    ExtSel = !is_zx;
                    RegWre = state == S_WB_AL;
                    RegDst = state == S_WB_AL && !is_imm;
                    PCWre = state == S_WB_AL;
                    nxt = state == S_WB_AL ? S_IF : S_WB_AL;
                end
                S_EXE_BR: begin
                    ALUOp = 3'b001;
                    ExtSel = 1'b1;
                    PCWre = 1'b1;
                    PCSrc = {1'b0, taken};
                    nxt = S_IF;
                end
                S_EXE_LS, S_WB_LD: begin
                    ALUSrcB = 1'b1;
                    ExtSel = 1'b1;
                    RegWre = state == S_WB_LD;
                    DBDataSrc = state == S_WB_LD;
                    PCWre = state == S_WB_LD;
                    nxt = state == S_WB_LD ? S_IF : S_MEM;
                end
                S_MEM: begin
                    ALUSrcB = 1'b1;
                    ExtSel = 1'b1;
                    mRD = is_lw;
                    mWR = !is_lw;
                    PCWre = MemReady && !is_lw;
                    nxt = MemReady ? (is_lw ? S_WB_LD : S_IF) :
                          tmo == 8'(MEM_TIMEOUT - 1) ? S_HALT : S_MEM;
                end
                S_HALT: nxt = S_HALT;
                default: nxt = S_IF;
            endcase
        end
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IF;
            op_q <= 6'd0;
            tmo <= 8'd0;
            MemErr <= 1'b0;
            InstrCount <= '0;
        end else begin
            state <= nxt;
            if (state == S_ID) op_q <= opcode;
            tmo <= state == S_MEM ? tmo + 8'd1 : 8'd0;
            if (state == S_MEM && nxt == S_HALT) MemErr <= 1'b1;
            if (PCWre) InstrCount <= InstrCount + 1'b1;
        end
    end
endmodule
